// File: rtl/spi_flash_read_ctrl.sv
// rtl/spi_flash_read_ctrl.sv - SPI flash READ sequencer: opcode + 24-bit address, then N data bytes
// Define SPI_FLASH_FAST_READ_EN to send FAST READ (0x0B) with one dummy byte after the address.
module spi_flash_read_ctrl #(
  parameter logic [7:0] CMD_READ    = 8'h03,
  parameter int         BYTE_CYCLES = 17,
  parameter int         LEN_W       = 16
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] length,
  input  logic             abort,
  output logic             busy,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             spi_enabled,
  output logic             spi_continue_read,
  output logic [7:0]       spi_data_in,
  input  logic [7:0]       spi_data_out
);

  localparam int CNT_W = $clog2(BYTE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_CYCLES);
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
`else
  localparam logic [7:0] OPCODE = CMD_READ;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DUMMY  = 3'd3,
    S_DATA   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_cyc_cnt, w_cyc_cnt;
  logic [1:0]       r_byte_idx, w_byte_idx;
  logic [23:0]      r_addr, w_addr;
  logic [LEN_W-1:0] r_remaining, w_remaining;
  logic             r_busy, w_busy;
  logic [7:0]       r_rd_data, w_rd_data;
  logic             r_rd_valid, w_rd_valid;
  logic             r_done, w_done;
  logic             r_spi_enabled, w_spi_enabled;
  logic             r_spi_continue, w_spi_continue;
  logic [7:0]       r_spi_data_in, w_spi_data_in;
  logic             w_byte_done;
  logic             w_start_ok;
  logic             w_abort_act;

  assign w_byte_done = r_spi_enabled && (r_cyc_cnt == CNT_LAST);
  assign w_start_ok  = start && !abort;
  assign w_abort_act = abort && (r_state != S_IDLE);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_cyc_cnt      <= '0;
      r_byte_idx     <= '0;
      r_addr         <= '0;
      r_remaining    <= '0;
      r_busy         <= 1'b0;
      r_rd_data      <= '0;
      r_rd_valid     <= 1'b0;
      r_done         <= 1'b0;
      r_spi_enabled  <= 1'b0;
      r_spi_continue <= 1'b0;
      r_spi_data_in  <= '0;
    end else begin
      r_state        <= w_next_state;
      r_cyc_cnt      <= w_cyc_cnt;
      r_byte_idx     <= w_byte_idx;
      r_addr         <= w_addr;
      r_remaining    <= w_remaining;
      r_busy         <= w_busy;
      r_rd_data      <= w_rd_data;
      r_rd_valid     <= w_rd_valid;
      r_done         <= w_done;
      r_spi_enabled  <= w_spi_enabled;
      r_spi_continue <= w_spi_continue;
      r_spi_data_in  <= w_spi_data_in;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_abort_act) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_start_ok && (length != '0)) w_next_state = S_CMD;
        S_CMD:    if (w_byte_done) w_next_state = S_ADDR;
        S_ADDR: begin
          if (w_byte_done && (r_byte_idx == 2'd2)) begin
`ifdef SPI_FLASH_FAST_READ_EN
            w_next_state = S_DUMMY;
`else
            w_next_state = S_DATA;
`endif
          end
        end
`ifdef SPI_FLASH_FAST_READ_EN
        S_DUMMY:  if (w_byte_done) w_next_state = S_DATA;
`endif
        S_DATA:   if (w_byte_done && (r_remaining == LEN_W'(1))) w_next_state = S_FINISH;
        S_FINISH: w_next_state = S_IDLE;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  // Every byte boundary either kicks the next byte (new data_in + continue pulse) or drops CS.
  always_comb begin
    w_cyc_cnt      = (r_spi_enabled && !w_byte_done) ? r_cyc_cnt + 1'b1 : r_cyc_cnt;
    w_byte_idx     = r_byte_idx;
    w_addr         = r_addr;
    w_remaining    = r_remaining;
    w_busy         = r_busy;
    w_rd_data      = r_rd_data;
    w_rd_valid     = 1'b0;
    w_done         = 1'b0;
    w_spi_enabled  = r_spi_enabled;
    w_spi_continue = 1'b0;
    w_spi_data_in  = r_spi_data_in;
    if (w_abort_act) begin
      w_spi_enabled = 1'b0;
      w_busy        = 1'b0;
      w_cyc_cnt     = '0;
      w_byte_idx    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            if (length != '0) begin
              w_addr        = addr;
              w_remaining   = length;
              w_spi_data_in = OPCODE;
              w_spi_enabled = 1'b1;
              w_cyc_cnt     = '0;
              w_byte_idx    = '0;
              w_busy        = 1'b1;
            end else begin
              w_done = 1'b1;
            end
          end
        end
        S_CMD: begin
          if (w_byte_done) begin
            w_spi_data_in  = r_addr[23:16];
            w_spi_continue = 1'b1;
            w_cyc_cnt      = '0;
            w_byte_idx     = '0;
          end
        end
        S_ADDR: begin
          if (w_byte_done) begin
            w_spi_continue = 1'b1;
            w_cyc_cnt      = '0;
            case (r_byte_idx)
              2'd0:    w_spi_data_in = r_addr[15:8];
              2'd1:    w_spi_data_in = r_addr[7:0];
              default: w_spi_data_in = 8'h00;
            endcase
            w_byte_idx = r_byte_idx + 2'd1;
          end
        end
`ifdef SPI_FLASH_FAST_READ_EN
        S_DUMMY: begin
          if (w_byte_done) begin
            w_spi_data_in  = 8'h00;
            w_spi_continue = 1'b1;
            w_cyc_cnt      = '0;
          end
        end
`endif
        S_DATA: begin
          if (w_byte_done) begin
            w_rd_data   = spi_data_out;
            w_rd_valid  = 1'b1;
            w_remaining = r_remaining - LEN_W'(1);
            w_cyc_cnt   = '0;
            if (r_remaining > LEN_W'(1)) begin
              w_spi_continue = 1'b1;
            end else begin
              w_spi_enabled = 1'b0;
            end
          end
        end
        S_FINISH: begin
          w_done = 1'b1;
          w_busy = 1'b0;
        end
        default: begin
          w_spi_enabled = 1'b0;
          w_busy        = 1'b0;
        end
      endcase
    end
  end

  assign busy              = r_busy;
  assign rd_data           = r_rd_data;
  assign rd_valid          = r_rd_valid;
  assign done              = r_done;
  assign spi_enabled       = r_spi_enabled;
  assign spi_continue_read = r_spi_continue;
  assign spi_data_in       = r_spi_data_in;

endmodule
